// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared types and helpers for the instruction-fetch stage.
//   if_state_e    : fetch FSM states
//   fetch_entry_t : (pc, instruction) pair carried to decode / held in the skid
//   KSEG_MASK     : strips the kseg0/kseg1 segment bits from a virtual PC
//   kseg_map()    : virtual PC -> bus address
// Build option: IF_KSEG_MAP_EN enables the kseg0/kseg1 address mapping.
// -----------------------------------------------------------------------------
package if_pkg;

   localparam int unsigned IF_ADDR_W = 32;
   localparam int unsigned IF_DATA_W = 32;

   localparam logic [31:0] KSEG_MASK = 32'h1fff_ffff;

`ifdef IF_KSEG_MAP_EN
   localparam bit KSEG_MAP_EN = 1'b1;
`else
   localparam bit KSEG_MAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DROP
   } if_state_e;

   typedef struct packed {
      logic [IF_ADDR_W-1:0] pc;
      logic [IF_DATA_W-1:0] inst;
   } fetch_entry_t;

   // kseg0/kseg1 (pc[31:30] == 2'b10) map onto the low 512 MB physical window.
   function automatic logic [IF_ADDR_W-1:0] kseg_map(input logic [IF_ADDR_W-1:0] pc);
      if (KSEG_MAP_EN && (pc[31:30] == 2'b10)) begin
         return pc & KSEG_MASK;
      end
      return pc;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Instruction-bus read channel between the fetch stage and the bus slave.
//   req    : read request valid          (master -> slave)
//   addr   : read address                (master -> slave)
//   gnt    : address accepted this cycle (slave -> master)
//   rvalid : read data valid             (slave -> master)
//   rdata  : read data                   (slave -> master)
// -----------------------------------------------------------------------------
interface inst_fetch_if
   import if_pkg::*;
#(
   parameter int unsigned ADDR_W = IF_ADDR_W,
   parameter int unsigned DATA_W = IF_DATA_W
);

   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );

endinterface

// File: rtl/if_skid_buf.sv
// -----------------------------------------------------------------------------
// if_skid_buf
// One-entry holding buffer for a fetched (pc, inst) pair that arrived while
// the decode output register was occupied and stalled.
//   clk, rst : clock, synchronous active-high reset
//   push     : capture din (buffer becomes full)
//   pop      : release the entry (buffer becomes empty)
//   clear    : discard the entry; wins over push and pop
//   din      : entry to capture
//   dout     : held entry
//   full     : entry present
// -----------------------------------------------------------------------------
module if_skid_buf
   import if_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  fetch_entry_t din,
   output fetch_entry_t dout,
   output logic         full
);

   // Clear wins, then push (a push never coincides with a pop in the fetch FSM).
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         dout <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (push) begin
         dout <= din;
         full <= 1'b1;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage between pc_reg and decode. Issues one instruction
// bus read at a time, pulses pc_reg's advance enable on each accepted address,
// and hands (pc, inst) pairs to decode through an output register backed by a
// one-entry skid buffer. Honours decode stall and pipeline flush.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   pc_i        : current PC from pc_reg (stable until pc_en_o)
//   pc_en_o     : advance enable to pc_reg, = gnt while requesting (combinational)
//   flush_i     : kill all undelivered / in-flight instructions
//   stall_i     : decode cannot accept this cycle
//   ibus        : instruction bus, master side
//   id_valid_o  : output instruction valid
//   id_pc_o     : virtual PC of output instruction
//   id_inst_o   : output instruction word
//
// Build option: IF_KSEG_MAP_EN maps kseg0/kseg1 PCs onto physical bus
// addresses (see if_pkg::kseg_map); id_pc_o always carries the virtual PC.
// -----------------------------------------------------------------------------
module inst_fetch
   import if_pkg::*;
#(
   parameter int unsigned ADDR_W = IF_ADDR_W,
   parameter int unsigned DATA_W = IF_DATA_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              pc_en_o,
   input  logic              flush_i,
   input  logic              stall_i,
   inst_fetch_if.master      ibus,
   output logic              id_valid_o,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [DATA_W-1:0] id_inst_o
);

   if_state_e         state;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] req_pc;

   logic              out_ready;
   logic              skid_push;
   logic              skid_pop;
   logic              skid_clear;
   logic              skid_full;
   fetch_entry_t      skid_din;
   fetch_entry_t      skid_dout;

   // The single combinational path: the grant is forwarded to pc_reg at once.
   assign pc_en_o   = (state == REQ) && ibus.gnt;
   assign ibus.req  = req_q;
   assign ibus.addr = addr_q;

   // Output register can take new data if empty or being consumed this edge.
   assign out_ready = !id_valid_o || !stall_i;

   // Skid buffer control.
   always_comb begin
      skid_clear = flush_i;
      skid_push  = (state == WAIT) && ibus.rvalid && !flush_i && !out_ready;
      skid_pop   = (state == HOLD) && !flush_i && !stall_i;
      skid_din   = '{pc: req_pc, inst: ibus.rdata};
   end

   if_skid_buf u_skid (
      .clk   (clk),
      .rst   (rst),
      .push  (skid_push),
      .pop   (skid_pop),
      .clear (skid_clear),
      .din   (skid_din),
      .dout  (skid_dout),
      .full  (skid_full)
   );

   // Fetch FSM and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_q      <= 1'b0;
         addr_q     <= '0;
         req_pc     <= '0;
         id_valid_o <= 1'b0;
         id_pc_o    <= '0;
         id_inst_o  <= '0;
      end else begin
         // pc_i only moves on pc_en_o, so a one-cycle-late copy is always
         // current by the time the FSM is back in REQ.
         addr_q <= kseg_map(pc_i);

         if (id_valid_o && !stall_i) begin
            id_valid_o <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               state <= REQ;
               req_q <= 1'b1;
            end

            REQ: begin
               if (ibus.gnt) begin
                  req_pc <= pc_i;
                  req_q  <= 1'b0;
                  state  <= flush_i ? DROP : WAIT;
               end
            end

            WAIT: begin
               if (flush_i) begin
                  if (ibus.rvalid) begin
                     state <= REQ;
                     req_q <= 1'b1;
                  end else begin
                     state <= DROP;
                  end
               end else if (ibus.rvalid) begin
                  if (out_ready) begin
                     id_valid_o <= 1'b1;
                     id_pc_o    <= req_pc;
                     id_inst_o  <= ibus.rdata;
                     state      <= REQ;
                     req_q      <= 1'b1;
                  end else begin
                     state <= HOLD;
                  end
               end
            end

            HOLD: begin
               if (flush_i) begin
                  state <= REQ;
                  req_q <= 1'b1;
               end else if (!stall_i && skid_full) begin
                  id_valid_o <= 1'b1;
                  id_pc_o    <= skid_dout.pc;
                  id_inst_o  <= skid_dout.inst;
                  state      <= REQ;
                  req_q      <= 1'b1;
               end
            end

            DROP: begin
               if (ibus.rvalid) begin
                  state <= REQ;
                  req_q <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase

         // Flush overrides stall and any load above.
         if (flush_i) begin
            id_valid_o <= 1'b0;
         end
      end
   end

   // Read data may only return while a request is outstanding.
   rvalid_in_window : assert property (@(posedge clk) disable iff (rst)
      ibus.rvalid |-> ((state == WAIT) || (state == DROP)));

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Self-checking bench for inst_fetch. Acts as pc_reg and instruction-bus slave;
// every instruction handed back on the bus that must reach decode is queued as
// (pc, inst) and matched against each decode-side consumption.
// Honours IF_KSEG_MAP_EN for the expected bus address.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
   import if_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        pc_en;
   logic        flush;
   logic        stall;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;

   int cmp_cnt   = 0;
   int err_cnt   = 0;
   int gnt_cnt   = 0;
   int pc_en_cnt = 0;

   fetch_entry_t sb[$];

   inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) ibus ();

   inst_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_i       (pc),
      .pc_en_o    (pc_en),
      .flush_i    (flush),
      .stall_i    (stall),
      .ibus       (ibus),
      .id_valid_o (id_valid),
      .id_pc_o    (id_pc),
      .id_inst_o  (id_inst)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

   function automatic logic [31:0] exp_addr(input logic [31:0] p);
`ifdef IF_KSEG_MAP_EN
      if (p >= 32'h8000_0000 && p < 32'hc000_0000) return {3'b000, p[28:0]};
`endif
      return p;
   endfunction

   // One clock: observe the cycle at the falling edge, then step to just past
   // the next rising edge. Decode consumptions are matched against the queue.
   task automatic tick();
      fetch_entry_t e;
      @(negedge clk);
      if (!rst && pc_en === 1'b1) pc_en_cnt++;
      if (!rst && id_valid === 1'b1 && !stall && !flush) begin
         cmp_cnt++;
         if (sb.size() == 0) begin
            err_cnt++;
            $display("FAIL deliver_extra: got pc=%h inst=%h, required nothing pending", id_pc, id_inst);
         end else begin
            e = sb.pop_front();
            if (id_pc !== e.pc || id_inst !== e.inst) begin
               err_cnt++;
               $display("FAIL deliver_order: got pc=%h inst=%h, required pc=%h inst=%h",
                        id_pc, id_inst, e.pc, e.inst);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ibus.req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         cmp_cnt++;
         err_cnt++;
         $display("FAIL req_timeout: ibus_req=%b, required 1 within 20 cycles", ibus.req);
      end
   endtask

   // Bus slave + pc_reg for one complete read that decode should receive.
   task automatic fetch(input int gnt_dly, input int rv_dly, input logic [31:0] inst);
      bit          ok;
      logic [31:0] p;
      wait_req(ok);
      if (!ok) return;
      repeat (gnt_dly) tick();
      cmp_cnt++;
      if (ibus.req !== 1'b1) begin
         err_cnt++;
         $display("FAIL req_held: ibus_req=%b, required 1", ibus.req);
      end
      p        = pc;
      ibus.gnt = 1'b1;
      #1;
      cmp_cnt++;
      if (pc_en !== 1'b1) begin
         err_cnt++;
         $display("FAIL pc_en_on_gnt: pc_en=%b, required 1", pc_en);
      end
      cmp_cnt++;
      if (ibus.addr !== exp_addr(p)) begin
         err_cnt++;
         $display("FAIL bus_addr: addr=%h, required %h", ibus.addr, exp_addr(p));
      end
      tick();
      ibus.gnt = 1'b0;
      gnt_cnt++;
      pc = pc + 32'd4;
      for (int i = 1; i < rv_dly; i++) begin
         cmp_cnt++;
         if (ibus.req !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_outstanding: ibus_req=%b while waiting, required 0", ibus.req);
         end
         tick();
      end
      ibus.rvalid = 1'b1;
      ibus.rdata  = inst;
      sb.push_back('{pc: p, inst: inst});
      cmp_cnt++;
      if (ibus.req !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_outstanding: ibus_req=%b on rvalid, required 0", ibus.req);
      end
      tick();
      ibus.rvalid = 1'b0;
      ibus.rdata  = '0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      flush       = 1'b0;
      stall       = 1'b0;
      ibus.gnt    = 1'b0;
      ibus.rvalid = 1'b0;
      ibus.rdata  = '0;
      pc          = 32'hbfc0_0000;
      repeat (3) tick();
      cmp_cnt++;
      if (ibus.req !== 1'b0) begin err_cnt++; $display("FAIL reset_req: got %b, required 0", ibus.req); end
      cmp_cnt++;
      if (pc_en !== 1'b0) begin err_cnt++; $display("FAIL reset_pc_en: got %b, required 0", pc_en); end
      cmp_cnt++;
      if (id_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_id_valid: got %b, required 0", id_valid); end
      cmp_cnt++;
      if (id_pc !== 32'h0) begin err_cnt++; $display("FAIL reset_id_pc: got %h, required 0", id_pc); end
      cmp_cnt++;
      if (id_inst !== 32'h0) begin err_cnt++; $display("FAIL reset_id_inst: got %h, required 0", id_inst); end
      rst = 1'b0;
      tick();
      cmp_cnt++;
      if (ibus.req !== 1'b1) begin err_cnt++; $display("FAIL idle_to_req: ibus_req=%b, required 1", ibus.req); end
   endtask

   task automatic test_first_fetch();
      int base;
      base = pc_en_cnt;
      fetch(0, 1, 32'h3c08_bfc0);
      cmp_cnt++;
      if (id_valid !== 1'b1) begin err_cnt++; $display("FAIL first_valid: got %b, required 1", id_valid); end
      cmp_cnt++;
      if (id_pc !== 32'hbfc0_0000) begin err_cnt++; $display("FAIL first_pc: got %h, required bfc00000", id_pc); end
      cmp_cnt++;
      if (id_inst !== 32'h3c08_bfc0) begin err_cnt++; $display("FAIL first_inst: got %h, required 3c08bfc0", id_inst); end
      repeat (2) tick();
      cmp_cnt++;
      if (pc_en_cnt - base !== 1) begin
         err_cnt++;
         $display("FAIL first_pc_en_once: got %0d pulses, required 1", pc_en_cnt - base);
      end
   endtask

   task automatic test_streaming();
      int base;
      base = pc_en_cnt;
      for (int i = 0; i < 3; i++) fetch(2, 1, 32'h2000_0000 + 32'(i));
      repeat (2) tick();
      cmp_cnt++;
      if (sb.size() != 0) begin err_cnt++; $display("FAIL stream_drained: %0d pending, required 0", sb.size()); end
      cmp_cnt++;
      if (pc_en_cnt - base !== 3) begin
         err_cnt++;
         $display("FAIL stream_pc_en: got %0d pulses, required 3", pc_en_cnt - base);
      end
   endtask

   task automatic test_stall_skid();
      logic [31:0] pb;
      stall = 1'b1;
      fetch(0, 1, 32'h2402_0000);
      pb = pc;
      fetch(0, 1, 32'h2402_0001);
      cmp_cnt++;
      if (ibus.req !== 1'b0) begin err_cnt++; $display("FAIL hold_no_req: ibus_req=%b, required 0", ibus.req); end
      cmp_cnt++;
      if (id_valid !== 1'b1 || id_inst !== 32'h2402_0000) begin
         err_cnt++;
         $display("FAIL hold_keeps_out: valid=%b inst=%h, required 1 24020000", id_valid, id_inst);
      end
      tick();
      cmp_cnt++;
      if (ibus.req !== 1'b0) begin err_cnt++; $display("FAIL hold_no_req2: ibus_req=%b, required 0", ibus.req); end
      stall = 1'b0;
      tick();
      cmp_cnt++;
      if (id_valid !== 1'b1 || id_inst !== 32'h2402_0001 || id_pc !== pb) begin
         err_cnt++;
         $display("FAIL skid_to_out: valid=%b pc=%h inst=%h, required 1 %h 24020001",
                  id_valid, id_pc, id_inst, pb);
      end
      cmp_cnt++;
      if (ibus.req !== 1'b1) begin err_cnt++; $display("FAIL skid_reissue: ibus_req=%b, required 1", ibus.req); end
      tick();
   endtask

   task automatic test_flush_wait();
      bit ok;
      stall = 1'b1;
      fetch(0, 1, 32'h1111_0000);
      wait_req(ok);
      if (!ok) return;
      ibus.gnt = 1'b1;
      #1;
      cmp_cnt++;
      if (pc_en !== 1'b1) begin err_cnt++; $display("FAIL fw_pc_en: got %b, required 1", pc_en); end
      tick();
      ibus.gnt = 1'b0;
      gnt_cnt++;
      pc = pc + 32'd4;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      sb.delete();
      cmp_cnt++;
      if (id_valid !== 1'b0) begin err_cnt++; $display("FAIL fw_out_cleared: id_valid=%b, required 0", id_valid); end
      stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cmp_cnt++;
         if (ibus.req !== 1'b0) begin err_cnt++; $display("FAIL fw_drop_no_req: ibus_req=%b, required 0", ibus.req); end
         tick();
      end
      ibus.rvalid = 1'b1;
      ibus.rdata  = 32'hdead_beef;
      cmp_cnt++;
      if (ibus.req !== 1'b0) begin err_cnt++; $display("FAIL fw_drop_no_req: ibus_req=%b, required 0", ibus.req); end
      tick();
      ibus.rvalid = 1'b0;
      ibus.rdata  = '0;
      cmp_cnt++;
      if (ibus.req !== 1'b1) begin err_cnt++; $display("FAIL fw_reissue: ibus_req=%b, required 1", ibus.req); end
      cmp_cnt++;
      if (id_valid !== 1'b0) begin err_cnt++; $display("FAIL fw_late_dropped: id_valid=%b, required 0", id_valid); end
      tick();
      cmp_cnt++;
      if (id_valid !== 1'b0) begin err_cnt++; $display("FAIL fw_late_dropped2: id_valid=%b, required 0", id_valid); end
   endtask

   task automatic test_flush_gnt();
      bit ok;
      wait_req(ok);
      if (!ok) return;
      ibus.gnt = 1'b1;
      flush    = 1'b1;
      #1;
      cmp_cnt++;
      if (pc_en !== 1'b1) begin err_cnt++; $display("FAIL fg_pc_en: got %b, required 1", pc_en); end
      tick();
      ibus.gnt = 1'b0;
      flush    = 1'b0;
      gnt_cnt++;
      pc = 32'h8000_1000;
      sb.delete();
      cmp_cnt++;
      if (ibus.req !== 1'b0) begin err_cnt++; $display("FAIL fg_drop_no_req: ibus_req=%b, required 0", ibus.req); end
      tick();
      ibus.rvalid = 1'b1;
      ibus.rdata  = 32'h0bad_0bad;
      tick();
      ibus.rvalid = 1'b0;
      ibus.rdata  = '0;
      cmp_cnt++;
      if (ibus.req !== 1'b1) begin err_cnt++; $display("FAIL fg_reissue: ibus_req=%b, required 1", ibus.req); end
      cmp_cnt++;
      if (id_valid !== 1'b0) begin err_cnt++; $display("FAIL fg_discarded: id_valid=%b, required 0", id_valid); end
      fetch(0, 1, 32'h3c1d_8000);
      tick();
      cmp_cnt++;
      if (sb.size() != 0) begin err_cnt++; $display("FAIL fg_target_delivered: %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_flush_hold();
      stall = 1'b1;
      fetch(0, 1, 32'h2403_0000);
      fetch(0, 1, 32'h2403_0001);
      cmp_cnt++;
      if (ibus.req !== 1'b0) begin err_cnt++; $display("FAIL fh_in_hold: ibus_req=%b, required 0", ibus.req); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      sb.delete();
      cmp_cnt++;
      if (id_valid !== 1'b0) begin err_cnt++; $display("FAIL fh_out_cleared: id_valid=%b, required 0", id_valid); end
      cmp_cnt++;
      if (ibus.req !== 1'b1) begin err_cnt++; $display("FAIL fh_reissue: ibus_req=%b, required 1", ibus.req); end
      stall = 1'b0;
      tick();
      cmp_cnt++;
      if (id_valid !== 1'b0) begin err_cnt++; $display("FAIL fh_skid_cleared: id_valid=%b, required 0", id_valid); end
      fetch(1, 2, 32'h2404_0000);
      tick();
      cmp_cnt++;
      if (sb.size() != 0) begin err_cnt++; $display("FAIL fh_recovered: %0d pending, required 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_streaming();
      test_stall_skid();
      test_flush_wait();
      test_flush_gnt();
      test_flush_hold();
      repeat (2) tick();
      cmp_cnt++;
      if (pc_en_cnt !== gnt_cnt) begin
         err_cnt++;
         $display("FAIL pc_en_total: got %0d pulses, required %0d", pc_en_cnt, gnt_cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage that sits between pc_reg and the decode stage.
- Takes the current PC from pc_reg and issues one instruction-bus read at a time.
- Pulses pc_reg's advance enable when the bus accepts the address.
- Delivers (pc, instruction) pairs to decode through an output register backed by a one-entry skid buffer.
- Honours decode stall and a pipeline flush (exception/eret).

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
pc_i  in  ADDR_W  current PC from pc_reg; stable until pc_en_o is seen
pc_en_o  out  1  advance-enable to pc_reg; one-cycle pulse per accepted request
flush_i  in  1  kill all undelivered/in-flight instructions
stall_i  in  1  decode cannot accept this cycle
ibus_req_o  out  1  read request valid
ibus_addr_o  out  ADDR_W  read address
ibus_gnt_i  in  1  address accepted this cycle
ibus_rvalid_i  in  1  read data valid (earliest the cycle after gnt)
ibus_rdata_i  in  DATA_W  read data
id_valid_o  out  1  output instruction valid
id_pc_o  out  ADDR_W  PC of output instruction
id_inst_o  out  DATA_W  output instruction

Behaviour:
- Reset:
  - state=IDLE.
  - ibus_req_o=0, pc_en_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
  - Skid buffer empty.
  - Reset mid-transaction abandons it; the bus slave must also be reset.
- FSM states: IDLE, REQ, WAIT, HOLD, DROP.
  - IDLE → REQ unconditionally on the first cycle after reset.
  - REQ:
    - ibus_req_o=1, ibus_addr_o=map(pc_i).
    - pc_en_o = ibus_gnt_i. This is combinational; it is the only comb path through the block.
    - On gnt: latch pc_i into req_pc. Go to WAIT, or to DROP if flush_i is high the same cycle.
  - WAIT:
    - ibus_req_o=0.
    - On rvalid, if the output register can accept (!id_valid_o || !stall_i): load id_pc_o=req_pc, id_inst_o=rdata, id_valid_o=1; go to REQ.
    - Otherwise write {req_pc, rdata} into the skid buffer; go to HOLD.
    - flush_i without rvalid → DROP.
    - flush_i with rvalid → discard the data; go to REQ.
  - HOLD:
    - No request issued.
    - When !stall_i: skid → output register, skid empty; go to REQ.
  - DROP:
    - Wait for rvalid, discard it, go to REQ.
    - Further flush_i in DROP has no extra effect.
- Output register:
  - Consumed at any edge where id_valid_o && !stall_i.
  - If it is consumed and not reloaded, id_valid_o goes to 0.
  - id_pc_o and id_inst_o hold their value while id_valid_o=0.
- flush_i:
  - Priority over stall_i and over data loads.
  - Next cycle: id_valid_o=0 and skid empty.
  - HOLD → REQ.
  - A gnt in the flush cycle still pulses pc_en_o, so pc_reg can consume its saved branch target.
- Only one outstanding request at any time.
- Best-case throughput is one instruction per 2 cycles.
- Latency: gnt at cycle t, rvalid at t+1 → id_valid_o=1 at t+2.
- ibus_rvalid_i outside WAIT/DROP is ignored and is a protocol error (assertion).
- No address arithmetic here; PC increment lives in pc_reg.

Optional Feature:
IF_KSEG_MAP_EN
- Defined: if pc_i[31:30]==2'b10 (kseg0/kseg1), ibus_addr_o = {3'b000, pc_i[28:0]}; otherwise ibus_addr_o = pc_i. For example, 0xbfc00000 maps to 0x1fc00000.
- Undefined: ibus_addr_o = pc_i.
- id_pc_o always carries the unmapped virtual PC.

Decomposition:
- Package if_pkg:
  - if_state_e enum (IDLE, REQ, WAIT, HOLD, DROP).
  - fetch_entry_t struct {pc, inst}.
  - KSEG_MASK constant 32'h1fffffff.
- One sub-module, if_skid_buf: one-entry buffer of fetch_entry_t with push, pop and clear, plus a full flag.

Test Plan:
- Reset then pc_i=0xbfc00000, gnt in the same cycle as the req, rvalid next cycle with 0x3c08bfc0:
  - pc_en_o pulses exactly once.
  - id_valid_o=1, id_pc_o=0xbfc00000, id_inst_o=0x3c08bfc0 two cycles after gnt.
  - With IF_KSEG_MAP_EN, ibus_addr_o=0x1fc00000.
- Streaming with no stall, gnt delayed 2 cycles per request: PCs 0x...00, 04, 08 delivered in order, one pc_en_o per gnt, never two requests outstanding.
- stall_i=1 while a new rvalid (inst 0x24020001) arrives with output occupied:
  - Data goes to skid; state HOLD, no ibus_req_o.
  - On stall_i=0: old instruction consumed, then 0x24020001 appears the next cycle.
- flush_i in WAIT, rvalid 3 cycles later:
  - id_valid_o=0 the cycle after flush.
  - The late data is never delivered.
  - Next request issued the cycle after the discarded rvalid.
- flush_i and gnt in the same REQ cycle: pc_en_o=1, state DROP, the response is discarded.
- flush_i together with stall_i=1 in HOLD: skid and output cleared, id_valid_o=0, request reissued the next cycle.
